// File: rtl/ram_pkg.sv
// Shared encodings for the data-side RAM port: access sizes, arbiter states, timeout default.
package ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit RAM word: store lane enables/replication, load extract/extend.
// Purely combinational, zero latency, no flow control.
module mem_lane_align
    import ram_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_unsigned,
    input  logic [31:0] i_dout,
    output logic [3:0]  o_we,
    output logic [31:0] o_din,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [31:0] w_shift;

    // o_misaligned also flags the reserved size encoding so callers need one legality bit.
    always_comb begin
        o_we         = 4'b0000;
        o_din        = 32'd0;
        o_rdata      = 32'd0;
        o_misaligned = 1'b0;
        w_shift      = i_dout >> {i_addr, 3'b000};
        case (i_size)
            SZ_BYTE: begin
                o_we    = 4'b0001 << i_addr;
                o_din   = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shift[7] & ~i_unsigned}}, w_shift[7:0]};
            end
            SZ_HALF: begin
                w_shift      = i_dout >> {i_addr[1], 4'b0000};
                o_we         = i_addr[1] ? 4'b1100 : 4'b0011;
                o_din        = {2{i_wdata[15:0]}};
                o_rdata      = {{16{w_shift[15] & ~i_unsigned}}, w_shift[15:0]};
                o_misaligned = i_addr[0];
            end
            SZ_WORD: begin
                o_we         = 4'b1111;
                o_din        = i_wdata;
                o_rdata      = i_dout;
                o_misaligned = |i_addr;
            end
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of the data RAM port for two requesters; one transaction in flight.
// Grant is combinational in IDLE; response one cycle after completion; requesters wait for req_ready.
module ram_port_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [3:0]            req_size,
    input  logic [1:0]            req_unsigned,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout,
    input  logic                  mem_read_valid,
    input  logic                  mem_ready
);

    arb_state_t        r_state, w_next;
    logic              r_last, r_id, r_we, r_uns, r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_mem_we;
    logic [31:0]       r_mem_din, r_rdata;
    logic [5:0]        r_cnt;

    logic              w_any, w_win, w_done, w_tmo;
    logic              w_sel_we, w_sel_uns;
    logic [1:0]        w_sel_size, w_al_size, w_al_addr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_al_uns, w_al_mis;
    logic [3:0]        w_al_we;
    logic [31:0]       w_al_din, w_al_rdata;

    assign w_any = |req_valid;
    // On a tie the requester not served last wins; otherwise the lone valid one.
    assign w_win = (&req_valid) ? ~r_last : req_valid[1];

    assign w_sel_we    = w_win ? req_we[1]                    : req_we[0];
    assign w_sel_uns   = w_win ? req_unsigned[1]              : req_unsigned[0];
    assign w_sel_size  = w_win ? req_size[3:2]                : req_size[1:0];
    assign w_sel_addr  = w_win ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_win ? req_wdata[63:32]             : req_wdata[31:0];

    // One aligner serves both the grant-time store steering and the busy-time load extract.
    assign w_al_size = (r_state == ST_IDLE) ? w_sel_size      : r_size;
    assign w_al_addr = (r_state == ST_IDLE) ? w_sel_addr[1:0] : r_addr[1:0];
    assign w_al_uns  = (r_state == ST_IDLE) ? w_sel_uns       : r_uns;

    mem_lane_align u_align (
        .i_size       (w_al_size),
        .i_addr       (w_al_addr),
        .i_wdata      (w_sel_wdata),
        .i_unsigned   (w_al_uns),
        .i_dout       (mem_dout),
        .o_we         (w_al_we),
        .o_din        (w_al_din),
        .o_rdata      (w_al_rdata),
        .o_misaligned (w_al_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // The first BUSY cycle (r_cnt == 1) never completes: the RAM port needs a cycle to start.
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        w_tmo  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_any) w_next = w_al_mis ? ST_RESP : ST_BUSY;
            ST_BUSY: begin
                w_done = (r_cnt != 6'd1) && (r_we ? mem_ready : mem_read_valid);
                w_tmo  = !w_done && (r_cnt == 6'(TIMEOUT));
                if (w_done || w_tmo) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_we      <= 1'b0;
            r_uns     <= 1'b0;
            r_err     <= 1'b0;
            r_size    <= SZ_BYTE;
            r_addr    <= '0;
            r_mem_we  <= 4'b0000;
            r_mem_din <= 32'd0;
            r_rdata   <= 32'd0;
            r_cnt     <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_last    <= w_win;
                    r_id      <= w_win;
                    r_we      <= w_sel_we;
                    r_uns     <= w_sel_uns;
                    r_size    <= w_sel_size;
                    r_addr    <= w_sel_addr;
                    r_mem_we  <= (w_sel_we && !w_al_mis) ? w_al_we : 4'b0000;
                    r_mem_din <= w_al_din;
                    r_err     <= w_al_mis;
                    r_rdata   <= 32'd0;
                    r_cnt     <= 6'd1;
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (w_done) begin
                        r_rdata  <= r_we ? 32'd0 : w_al_rdata;
                        r_mem_we <= 4'b0000;
                    end else if (w_tmo) begin
                        r_err    <= 1'b1;
                        r_rdata  <= 32'd0;
                        r_mem_we <= 4'b0000;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE && w_any) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_err   = r_err;
    assign rsp_rdata = r_rdata;
    assign mem_en    = (r_state == ST_BUSY);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a byte-arithmetic reference model.
module tb_ram_port_arbiter;

    localparam int AW  = 17;
    localparam int TMO = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_we, req_unsigned;
    logic [3:0]      req_size;
    logic [2*AW-1:0] req_addr;
    logic [63:0]     req_wdata;
    logic            rsp_valid, rsp_id, rsp_err;
    logic [31:0]     rsp_rdata;
    logic            mem_en;
    logic [3:0]      mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_din, mem_dout;
    logic            mem_read_valid, mem_ready;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_read_valid(mem_read_valid), .mem_ready(mem_ready)
    );

    typedef struct {
        bit          we;
        bit [1:0]    size;
        bit          uns;
        bit [AW-1:0] addr;
        bit [31:0]   wdata;
    } req_t;

    req_t rq[2];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_last  = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic req_t mk(bit we, bit [1:0] size, bit uns, bit [AW-1:0] addr, bit [31:0] wdata);
        req_t r;
        r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic int nbytes(bit [1:0] s);
        return 1 << s;
    endfunction

    function automatic bit is_legal(req_t r);
        if (r.size == 2'b11) return 1'b0;
        return (int'(r.addr) % nbytes(r.size)) == 0;
    endfunction

    function automatic bit [31:0] low_mask(bit [1:0] s);
        longint m;
        m = (longint'(1) << (8 * nbytes(s))) - 1;
        return m[31:0];
    endfunction

    function automatic bit [3:0] exp_we(req_t r);
        int m;
        m = ((1 << nbytes(r.size)) - 1) << (int'(r.addr) % 4);
        return r.we ? m[3:0] : 4'b0000;
    endfunction

    function automatic bit [31:0] exp_din(req_t r);
        bit [31:0] d;
        int nb;
        d  = 32'd0;
        nb = nbytes(r.size);
        for (int i = 0; i < 4 / nb; i++)
            d |= (r.wdata & low_mask(r.size)) << (8 * nb * i);
        return d;
    endfunction

    function automatic bit [31:0] exp_rdata(req_t r, bit [31:0] dout);
        bit [31:0] lm, v;
        lm = low_mask(r.size);
        v  = (dout >> (8 * (int'(r.addr) % 4))) & lm;
        if (!r.uns && v[8 * nbytes(r.size) - 1]) v |= ~lm;
        return v;
    endfunction

    // Present rq[] with the given valid mask, follow the granted transaction to its response.
    // lat = BUSY cycle index of the completion pulse (0 = never); hold keeps the winner valid.
    task automatic run_txn(input bit [1:0] vld, input bit [31:0] dout, input int lat, input bit hold);
        int        w, exp_rsp;
        req_t      r;
        bit        legal, tmo, busy_bad, comp;
        bit [3:0]  ewe;
        bit [31:0] edin, erd;
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        for (int i = 0; i < 2; i++) begin
            req_we[i]           = rq[i].we;
            req_unsigned[i]     = rq[i].uns;
            req_size[2*i +: 2]  = rq[i].size;
            req_addr[AW*i +: AW] = rq[i].addr;
            req_wdata[32*i +: 32] = rq[i].wdata;
        end
        req_valid = vld;
        #1;
        w = (vld == 2'b11) ? (m_last ? 0 : 1) : (vld[1] ? 1 : 0);
        check("grant", req_ready, 32'(1 << w));
        m_last  = w[0];
        r       = rq[w];
        legal   = is_legal(r);
        tmo     = legal && !(lat >= 2 && lat <= TMO);
        ewe     = legal ? exp_we(r) : 4'b0000;
        edin    = exp_din(r);
        exp_rsp = !legal ? 1 : (tmo ? TMO + 1 : lat + 1);
        erd     = (!legal || tmo || r.we) ? 32'd0 : exp_rdata(r, dout);
        busy_bad = 1'b0;
        for (int k = 1; k <= exp_rsp; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid[w] = 1'b0;
            if (k < exp_rsp) begin
                if (mem_en !== 1'b1 || mem_we !== ewe || mem_addr !== r.addr ||
                    rsp_valid !== 1'b0 || req_ready !== 2'b00 || (r.we && mem_din !== edin))
                    busy_bad = 1'b1;
            end else begin
                check("rsp_valid", rsp_valid, 1);
                check("rsp_id", rsp_id, w);
                check("rsp_err", rsp_err, !legal || tmo);
                check("rsp_rdata", rsp_rdata, erd);
                check("resp_mem_en", mem_en, 0);
                check("resp_no_grant", req_ready, 0);
            end
            comp = (k == lat) || (k == 1);
            if (r.we) begin
                mem_ready      = comp;
                mem_read_valid = 1'($urandom);
            end else begin
                mem_read_valid = comp;
                mem_ready      = 1'($urandom);
            end
            mem_dout = (k == lat) ? dout : $urandom;
        end
        if (legal) check("busy_hold", busy_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req_valid = 2'b00; req_we = 2'b00; req_size = 4'd0; req_unsigned = 2'b00;
        req_addr = '0; req_wdata = 64'd0;
        mem_dout = 32'd0; mem_read_valid = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        rst = 1'b0;

        rq[0] = mk(1'b0, 2'd2, 1'b0, 17'h00104, 32'd0);
        run_txn(2'b01, 32'hDEADBEEF, 3, 1'b0);
        rq[1] = mk(1'b1, 2'd0, 1'b0, 17'h00003, 32'h000000A5);
        run_txn(2'b10, 32'd0, 2, 1'b0);
        rq[0] = mk(1'b0, 2'd0, 1'b0, 17'h00012, 32'd0);
        run_txn(2'b01, 32'h0080FF00, 3, 1'b0);
        rq[0].uns = 1'b1;
        run_txn(2'b01, 32'h0080FF00, 3, 1'b0);
        rq[0] = mk(1'b0, 2'd1, 1'b0, 17'h00001, 32'd0);
        run_txn(2'b01, 32'h12345678, 3, 1'b0);
        rq[0] = mk(1'b0, 2'd2, 1'b0, 17'h00100, 32'd0);
        run_txn(2'b01, 32'h12345678, 0, 1'b0);
        rq[1] = mk(1'b1, 2'd1, 1'b0, 17'h00022, 32'h0000BEEF);
        run_txn(2'b10, 32'd0, TMO, 1'b0);

        // Reset during the second BUSY cycle of a read drops it silently.
        @(negedge clk);
        rq[0] = mk(1'b0, 2'd2, 1'b0, 17'h00200, 32'd0);
        req_we[0] = 1'b0; req_size[1:0] = 2'd2; req_addr[AW-1:0] = rq[0].addr;
        req_valid = 2'b01;
        mem_read_valid = 1'b0; mem_ready = 1'b0;
        #1;
        check("rstmid_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        check("rstmid_busy", mem_en, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_mem_en", mem_en, 0);
        check("rstmid_no_rsp", rsp_valid, 0);
        rst = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
        check("rstmid_no_rsp_late", rsp_valid, 0);

        // Both requesters valid continuously: grants must alternate starting with 0.
        rq[0] = mk(1'b0, 2'd2, 1'b0, 17'h00010, 32'd0);
        rq[1] = mk(1'b1, 2'd2, 1'b0, 17'h00020, 32'hCAFEF00D);
        for (int n = 0; n < 4; n++) begin
            run_txn(2'b11, $urandom, 3, 1'b1);
            check("alternate", m_last, n % 2);
        end

        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < 2; i++)
                rq[i] = mk(1'($urandom),
                           ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                           1'($urandom), AW'($urandom), $urandom);
            run_txn(2'($urandom_range(1, 3)), $urandom,
                    ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6), 1'($urandom));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the data-side RAM port between two requesters: 0 = load/store unit, 1 = program loader/debug. It grants one transaction at a time with round-robin priority and holds the RAM port enable for the full multi-cycle access. It generates byte-lane write enables and replicated store data, then returns load data extracted and sign/zero-extended. It sits between the requesters and the RAM I/O wrapper and is the only driver of that port.

## Interface
- ADDR_W, 17, byte address width into RAM.
- TIMEOUT, 15, max BUSY cycles before a transaction is aborted with an error (1..63).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester grant; one-hot or zero.
- req_we  in  2  per-requester write (1) / read (0).
- req_size  in  4  2 bits per requester: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  2  per-requester zero-extend loads.
- req_addr  in  2*ADDR_W  per-requester byte address.
- req_wdata  in  64  per-requester store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_err  out  1  misaligned, illegal size, or timeout.
- rsp_rdata  out  32  extended load data; 0 for writes and errors.
- mem_en  out  1  RAM port enable, held for the whole access.
- mem_we  out  4  byte-lane write enables.
- mem_addr  out  ADDR_W  latched byte address.
- mem_din  out  32  lane-replicated store data.
- mem_dout  in  32  raw RAM word.
- mem_read_valid  in  1  read-complete pulse from RAM port.
- mem_ready  in  1  RAM port idle/ready.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE, any req_valid: pick a winner, assert its req_ready combinationally, and latch its fields. A legal request moves to BUSY; an illegal one goes directly to RESP with err=1 and no RAM access.
- Arbitration: if both requesters are valid, the one not served last wins. last_served resets to 1, so requester 0 wins the first tie.
- Legality: half needs addr[0]=0; word needs addr[1:0]=0; size 11 is always illegal.
- Store lanes:
  - byte: mem_we=1<<addr[1:0], mem_din={4{wdata[7:0]}}.
  - half: mem_we=addr[1]?1100:0011, mem_din={2{wdata[15:0]}}.
  - word: mem_we=1111, mem_din=wdata.
  - reads: mem_we=0000.
- BUSY: mem_en=1, all mem_* outputs stable.
  - A read completes on a cycle with mem_read_valid=1, excluding the first BUSY cycle.
  - A write completes on a cycle with mem_ready=1, excluding the first BUSY cycle.
  - Completion moves to RESP. mem_dout is captured on the read completion cycle.
- Timeout: the BUSY cycle counter reaching TIMEOUT moves to RESP with err=1 and rdata=0.
- Load extract: shift mem_dout right by 8*addr[1:0] (half: 16*addr[1]). Keep 8/16/32 bits, then sign-extend unless the request was unsigned.
- RESP: rsp_valid=1 for one cycle with mem_en=0, then IDLE. This guaranteed idle cycle returns the RAM port FSM to its idle state. No grant is issued in RESP.

## Timing
- Reset values: state=IDLE, req_ready=00, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, last_served=1.
- Grant cycle T0 is IDLE with req_valid; BUSY starts at T1.
- A nominal read (mem_read_valid at T3) gives rsp_valid at T4; the next grant is possible at T5.
- A nominal write (mem_ready at T2) gives rsp_valid at T3.
- An illegal request gives rsp_valid at T1.
- A requester must hold req_valid and its fields until req_ready. Fields are don't-care after the grant.
- Deasserting req_valid before grant is legal; no transaction occurs.
- rst during BUSY or RESP drops the transaction: no response, mem_en=0 on the next cycle.
- mem_read_valid or mem_ready outside BUSY is ignored.

## Structure
- Shared package ram_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), arbiter state encodings, TIMEOUT default.
- Sub-module mem_lane_align (combinational):
  - Inputs: size, addr[1:0], wdata, unsigned, dout.
  - Outputs: we, din, extracted rdata, misaligned.
- It is reusable by the fetch side.

## Test plan
- Req0 word read, addr=0x00104, RAM returns 0xDEADBEEF with mem_read_valid at T3 -> rsp_valid at T4, id=0, rdata=0xDEADBEEF, err=0.
- Req1 byte write, addr=0x00003, wdata=0xA5 -> mem_we=1000, mem_din=0xA5A5A5A5 held through BUSY, rsp at T3, rdata=0.
- Req0 signed byte read at addr 0x...2 with dout=0x0080FF00 -> rdata=0xFFFFFF80. Same request with unsigned=1 -> rdata=0x00000080.
- Both valid every cycle from reset -> grants alternate 0,1,0,1; never both req_ready high.
- Half read at addr 0x00001 -> rsp at T1 with err=1, mem_en never asserted. No mem_read_valid for 15 BUSY cycles -> timeout rsp with err=1.
- rst asserted at the second BUSY cycle of a read -> next cycle mem_en=0, no rsp_valid, and the arbiter grants a fresh request normally.
